// File: rtl/spi_slv.sv
// Purpose : mode-3 SPI responder; captures one WIDTH-bit command per SS_n low period and shifts back a preloaded response.
// Latency : rdy/frm_err 3 clk edges after SS_n rises at the pin; MISO 3 clk edges after an SCLK fall at the pin.
// Backpr. : none; the master owns the bus timing, so rx_data must be consumed before the next frame completes.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   SS_n, SCLK, MOSI serial inputs from the master (asynchronous, synchronized here)
//   MISO             serial response to the master
//   tx_data, wrt_tx  response word and its one-cycle load strobe
//   rx_data, rdy     last complete command and its one-cycle update pulse
//   frm_err          one-cycle pulse: frame ended with the wrong bit count
//   busy             high while a frame is in progress
module spi_slv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SS_n,
    input  logic             SCLK,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             wrt_tx,
    output logic [WIDTH-1:0] rx_data,
    output logic             rdy,
    output logic             frm_err,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t           state;

    // Two synchronizer flops per input, plus a third on SS_n/SCLK for edge detection.
    logic             ss_s1, ss_s2, ss_s3;
    logic             sclk_s1, sclk_s2, sclk_s3;
    logic             mosi_s1, mosi_s2;

    logic [WIDTH-1:0] tx_buf;
    logic [WIDTH-1:0] shft;
    logic [4:0]       bit_cnt;

    // The sync chains reset to "idle" values, so a frame already in flight
    // when reset drops would look like a fresh SS_n fall. sync_vld counts
    // until the chain holds real pin data; armed then waits for SS_n to be
    // seen high before any frame may start, which discards the tail of an
    // aborted frame.
    logic [1:0]       sync_vld;
    logic             armed;

    logic             ss_fall, ss_rise;
    logic             sclk_fall, sclk_rise;
    logic [WIDTH-1:0] ld_val;

    assign ss_fall   = ~ss_s2 & ss_s3;
    assign ss_rise   = ss_s2 & ~ss_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;
    assign sclk_rise = sclk_s2 & ~sclk_s3;

    // A response written in the very cycle the frame starts goes straight out.
    assign ld_val    = wrt_tx ? tx_data : tx_buf;

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_s1    <= 1'b1;
            ss_s2    <= 1'b1;
            ss_s3    <= 1'b1;
            sclk_s1  <= 1'b1;
            sclk_s2  <= 1'b1;
            sclk_s3  <= 1'b1;
            mosi_s1  <= 1'b0;
            mosi_s2  <= 1'b0;
            sync_vld <= 2'd0;
            armed    <= 1'b0;
            MISO     <= 1'b0;
            rx_data  <= '0;
            tx_buf   <= '0;
            shft     <= '0;
            bit_cnt  <= 5'd0;
            rdy      <= 1'b0;
            frm_err  <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
        end else begin
            ss_s1   <= SS_n;
            ss_s2   <= ss_s1;
            ss_s3   <= ss_s2;
            sclk_s1 <= SCLK;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;

            if (sync_vld != 2'd3) begin
                sync_vld <= sync_vld + 2'd1;
            end
            if (sync_vld == 2'd3 && ss_s2) begin
                armed <= 1'b1;
            end

            rdy     <= 1'b0;
            frm_err <= 1'b0;

            if (wrt_tx) begin
                tx_buf <= tx_data;
            end

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (ss_fall && armed) begin
                        shft    <= ld_val;
                        bit_cnt <= 5'd0;
                        MISO    <= ld_val[WIDTH-1];
                        busy    <= 1'b1;
                        state   <= ACTIVE;
                    end else begin
                        MISO <= 1'b0;
                    end
                end

                ACTIVE: begin
                    busy <= 1'b1;
                    // End of frame wins over any SCLK edge seen in the same cycle.
                    if (ss_rise) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        MISO  <= 1'b0;
                        if (bit_cnt == 5'(WIDTH)) begin
                            rx_data <= shft;
                            rdy     <= 1'b1;
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        // The first fall re-drives the MSB loaded at frame start.
                        MISO <= shft[WIDTH-1];
                    end else if (sclk_rise) begin
                        shft <= {shft[WIDTH-2:0], mosi_s2};
                        if (bit_cnt != 5'd31) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slv.sv
// Purpose : directed self-checking bench for spi_slv with a behavioural mode-3 master.
// Latency : master half-period is 17 clk; checks sample at negedge or #1 after posedge.
// Backpr. : not applicable.
module tb_spi_slv;

    logic        clk;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [15:0] tx_data;
    logic        wrt_tx;
    logic [15:0] rx_data;
    logic        rdy;
    logic        frm_err;
    logic        busy;

    int checks;
    int errors;
    int rdy_cnt;
    int err_cnt;
    int exp_rdy;
    int exp_err;

    logic [15:0] rd;

    spi_slv #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .tx_data (tx_data),
        .wrt_tx  (wrt_tx),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters: a stretched pulse counts more than once.
    always @(negedge clk) begin
        rdy_cnt <= rdy_cnt + (rdy ? 1 : 0);
        err_cnt <= err_cnt + (frm_err ? 1 : 0);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Mode-3 master: SCLK idles high, MOSI driven on fall, MISO sampled just
    // before the rise. Optional hooks: wrt_tx pulse during bit wr_at, reset
    // pulse before bit rst_at, wrt_tx coinciding with the slave's ss_fall.
    task automatic master(input int nbits, input logic [15:0] cmd,
                          input int wr_at, input logic [15:0] wr_val,
                          input int rst_at,
                          input logic byp, input logic [15:0] byp_val,
                          output logic [15:0] rd_o);
        logic [15:0] sh;
        sh   = 16'h0000;
        SS_n = 1'b0;
        if (byp) begin
            // SS_n low seen at posedge 1, s2 at posedge 2, ss_fall acted on at posedge 3.
            tick(2);
            tx_data = byp_val;
            wrt_tx  = 1'b1;
            tick(1);
            wrt_tx  = 1'b0;
            tick(14);
        end else begin
            tick(17);
        end
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                chk("busy_before_rst", {31'd0, busy}, 32'd1);
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                tick(3);
                chk("miso_after_rst", {31'd0, MISO}, 32'd0);
                chk("busy_after_rst", {31'd0, busy}, 32'd0);
            end
            SCLK = 1'b0;
            MOSI = (i < 16) ? cmd[15-i] : 1'b0;
            if (i == wr_at) begin
                tx_data = wr_val;
                wrt_tx  = 1'b1;
                tick(1);
                wrt_tx  = 1'b0;
                tick(16);
            end else begin
                tick(17);
            end
            sh   = {sh[14:0], MISO};
            SCLK = 1'b1;
            tick(17);
        end
        SS_n = 1'b1;
        rd_o = sh;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rdy_cnt = 0;
        err_cnt = 0;
        exp_rdy = 0;
        exp_err = 0;
        rst     = 1'b1;
        SS_n    = 1'b1;
        SCLK    = 1'b1;
        MOSI    = 1'b0;
        tx_data = 16'h0000;
        wrt_tx  = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(1);

        chk("rst_miso",    {31'd0, MISO},    32'd0);
        chk("rst_rx_data", {16'd0, rx_data}, 32'd0);
        chk("rst_rdy",     {31'd0, rdy},     32'd0);
        chk("rst_frm_err", {31'd0, frm_err}, 32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        tick(5);

        // 1: single frame, response A5C3, command 1234, rdy timing.
        tx_data = 16'hA5C3;
        wrt_tx  = 1'b1;
        tick(1);
        wrt_tx  = 1'b0;
        tick(3);
        master(16, 16'h1234, -1, 16'h0, -1, 1'b0, 16'h0, rd);
        @(posedge clk);
        @(posedge clk);
        #1 chk("t1_rdy_edge2", {31'd0, rdy}, 32'd0);
        @(posedge clk);
        #1 chk("t1_rdy_edge3", {31'd0, rdy}, 32'd1);
        @(posedge clk);
        #1 chk("t1_rdy_edge4", {31'd0, rdy}, 32'd0);
        tick(20);
        exp_rdy += 1;
        chk("t1_rd",      {16'd0, rd},      32'h0000_A5C3);
        chk("t1_rx_data", {16'd0, rx_data}, 32'h0000_1234);
        chk("t1_rdy_cnt", rdy_cnt,          exp_rdy);
        chk("t1_err_cnt", err_cnt,          exp_err);
        chk("t1_busy",    {31'd0, busy},    32'd0);
        chk("t1_miso",    {31'd0, MISO},    32'd0);

        // 2: back-to-back frames, response repeats.
        tx_data = 16'h8001;
        wrt_tx  = 1'b1;
        tick(1);
        wrt_tx  = 1'b0;
        tick(3);
        master(16, 16'hFFFF, -1, 16'h0, -1, 1'b0, 16'h0, rd);
        tick(10);
        exp_rdy += 1;
        chk("t2_rd_a",  {16'd0, rd},      32'h0000_8001);
        chk("t2_rx_a",  {16'd0, rx_data}, 32'h0000_FFFF);
        master(16, 16'h0000, -1, 16'h0, -1, 1'b0, 16'h0, rd);
        tick(10);
        exp_rdy += 1;
        chk("t2_rd_b",  {16'd0, rd},      32'h0000_8001);
        chk("t2_rx_b",  {16'd0, rx_data}, 32'h0000_0000);
        chk("t2_rdy_cnt", rdy_cnt, exp_rdy);

        // 3: reload mid-frame only affects the following frame.
        tx_data = 16'h1111;
        wrt_tx  = 1'b1;
        tick(1);
        wrt_tx  = 1'b0;
        tick(3);
        master(16, 16'h2468, 5, 16'h0F0F, -1, 1'b0, 16'h0, rd);
        tick(10);
        exp_rdy += 1;
        chk("t3_rd_cur", {16'd0, rd},      32'h0000_1111);
        chk("t3_rx_cur", {16'd0, rx_data}, 32'h0000_2468);
        master(16, 16'h1357, -1, 16'h0, -1, 1'b0, 16'h0, rd);
        tick(10);
        exp_rdy += 1;
        chk("t3_rd_next", {16'd0, rd},      32'h0000_0F0F);
        chk("t3_rx_next", {16'd0, rx_data}, 32'h0000_1357);

        // 4: short and long frames flag an error and leave rx_data alone.
        master(9, 16'hABCD, -1, 16'h0, -1, 1'b0, 16'h0, rd);
        tick(10);
        exp_err += 1;
        chk("t4_err_short", err_cnt, exp_err);
        master(17, 16'hCAFE, -1, 16'h0, -1, 1'b0, 16'h0, rd);
        tick(10);
        exp_err += 1;
        chk("t4_err_long", err_cnt,          exp_err);
        chk("t4_rdy_cnt",  rdy_cnt,          exp_rdy);
        chk("t4_rx_keep",  {16'd0, rx_data}, 32'h0000_1357);

        // 5: reset after 8 bits aborts silently; next full frame is clean.
        master(16, 16'hBEEF, -1, 16'h0, 8, 1'b0, 16'h0, rd);
        tick(10);
        chk("t5_rdy_abort", rdy_cnt,          exp_rdy);
        chk("t5_err_abort", err_cnt,          exp_err);
        chk("t5_rx_reset",  {16'd0, rx_data}, 32'h0000_0000);
        master(16, 16'h5555, -1, 16'h0, -1, 1'b0, 16'h0, rd);
        tick(10);
        exp_rdy += 1;
        chk("t5_rx",      {16'd0, rx_data}, 32'h0000_5555);
        chk("t5_rd",      {16'd0, rd},      32'h0000_0000);
        chk("t5_rdy_cnt", rdy_cnt,          exp_rdy);

        // 6: wrt_tx coinciding with frame start is bypassed onto MISO and retained.
        master(16, 16'hC3A5, -1, 16'h0, -1, 1'b1, 16'h7E7E, rd);
        tick(10);
        exp_rdy += 1;
        chk("t6_rd_byp", {16'd0, rd},      32'h0000_7E7E);
        chk("t6_rx",     {16'd0, rx_data}, 32'h0000_C3A5);
        master(16, 16'h0F1E, -1, 16'h0, -1, 1'b0, 16'h0, rd);
        tick(10);
        exp_rdy += 1;
        chk("t6_rd_buf", {16'd0, rd}, 32'h0000_7E7E);
        chk("t6_rdy_cnt", rdy_cnt, exp_rdy);
        chk("t6_err_cnt", err_cnt, exp_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
